// File: rtl/imm_gen_pipe.sv
// Registered rv32i immediate generator: decodes fmt/imm and pc+imm with one cycle of latency.
// A one-entry skid buffer keeps in_ready a pure flop output; flush drops both held entries.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter bit          EN_SHAMT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
    } res_t;

    res_t        dec;
    res_t        out_q;
    res_t        skid_q;
    logic        skid_valid;
    logic [31:0] imm32;
    logic        is_shamt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    always_comb begin
        imm32    = '0;
        dec.fmt  = FMT_ILL;
        is_shamt = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0010011: begin
                dec.fmt  = FMT_I;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                is_shamt = EN_SHAMT && (funct3 == 3'b001 || funct3 == 3'b101);
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            7'b0110011: dec.fmt = FMT_R;
            default:    dec.fmt = FMT_ILL;
        endcase

        // imm32 is already sign-correct; widening to XLEN replicates bit 31 (U-type on RV64 too)
        dec.imm = XLEN'($signed(imm32));
        if (is_shamt) begin
            dec.imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
        end
        dec.target = in_pc + dec.imm;
        dec.pc     = in_pc;
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // output slot is free this cycle; skid (older) wins over a new accept
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_imm    = out_q.imm;
    assign out_fmt    = out_q.fmt;
    assign out_target = out_q.target;
    assign out_pc     = out_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (RV32 shamt on, RV32 shamt off, RV64) share one stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    logic        in_ready_a, out_valid_a, in_ready_n, out_valid_n, in_ready_w, out_valid_w;
    logic [31:0] out_imm_a, out_target_a, out_pc_a, out_imm_n, out_target_n, out_pc_n;
    logic [2:0]  out_fmt_a, out_fmt_n, out_fmt_w;
    logic [63:0] out_imm_w, out_target_w, out_pc_w;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } ent_t;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .EN_SHAMT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_target(out_target_a), .out_pc(out_pc_a));

    imm_gen_pipe #(.XLEN(32), .EN_SHAMT(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_imm(out_imm_n), .out_fmt(out_fmt_n), .out_target(out_target_n), .out_pc(out_pc_n));

    imm_gen_pipe #(.XLEN(64), .EN_SHAMT(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_imm(out_imm_w), .out_fmt(out_fmt_w), .out_target(out_target_w), .out_pc(out_pc_w));

    // Reference decode: immediates as signed field values scaled by their implied low zeros.
    function automatic void ref_dec(input logic [31:0] ins, input int xlen, input bit en_sh,
                                    output logic [63:0] imm, output logic [2:0] fmt);
        longint             v;
        logic signed [11:0] s12;
        logic signed [19:0] s20;
        v = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin fmt = 3'd1; s12 = ins[31:20]; v = longint'(s12); end
            7'h23: begin fmt = 3'd2; s12 = {ins[31:25], ins[11:7]}; v = longint'(s12); end
            7'h63: begin
                fmt = 3'd3; s12 = {ins[31], ins[7], ins[30:25], ins[11:8]}; v = longint'(s12) * 2;
            end
            7'h37, 7'h17: begin fmt = 3'd4; s20 = ins[31:12]; v = longint'(s20) * 4096; end
            7'h6F: begin
                fmt = 3'd5; s20 = {ins[31], ins[19:12], ins[20], ins[30:21]}; v = longint'(s20) * 2;
            end
            7'h33:   fmt = 3'd0;
            default: fmt = 3'd7;
        endcase
        if (en_sh && ins[6:0] == 7'h13 && ins[13:12] == 2'b01)
            v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        imm = v;
        if (xlen == 32) imm[63:32] = '0;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_a); end
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_a); end
        total++;
        if ({out_imm_a, out_fmt_a, out_target_a, out_pc_a} !== '0) begin
            bad++; $display("FAIL reset_fields got imm=%h fmt=%0d tgt=%h pc=%h want all 0",
                            out_imm_a, out_fmt_a, out_target_a, out_pc_a);
        end
        total++; if (out_imm_w !== 64'h0) begin bad++; $display("FAIL reset_imm64 got=%h want=0", out_imm_w); end
        do_reset();
    endtask

    task automatic test_addi();
        drive(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0);
        total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b want=1", out_valid_a); end
        total++; if (out_fmt_a !== 3'd1) begin bad++; $display("FAIL addi_fmt got=%0d want=1", out_fmt_a); end
        total++; if (out_imm_a !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h want=ffffffff", out_imm_a); end
        total++; if (out_target_a !== 32'h000000FF) begin bad++; $display("FAIL addi_target got=%h want=000000ff", out_target_a); end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b want=0", out_valid_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins_t [4] = '{32'h123450B7, 32'h00112223, 32'h00000463, 32'hFFDFF06F};
        logic [31:0] pc_t  [4] = '{32'h0, 32'h0, 32'h100, 32'h200};
        logic [2:0]  fmt_t [4] = '{3'd4, 3'd2, 3'd3, 3'd5};
        logic [31:0] imm_t [4] = '{32'h12345000, 32'h4, 32'h8, 32'hFFFFFFFC};
        logic [31:0] tgt_t [4] = '{32'h12345000, 32'h4, 32'h108, 32'h1FC};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ins_t[i], {32'h0, pc_t[i]}, 1'b1, 1'b0);
            total++;
            if (out_valid_a !== 1'b1 || in_ready_a !== 1'b1) begin
                bad++; $display("FAIL b2b_hs[%0d] got vld=%b rdy=%b want 1/1", i, out_valid_a, in_ready_a);
            end
            total++;
            if (out_fmt_a !== fmt_t[i] || out_imm_a !== imm_t[i] || out_target_a !== tgt_t[i]) begin
                bad++; $display("FAIL b2b_res[%0d] got fmt=%0d imm=%h tgt=%h want fmt=%0d imm=%h tgt=%h",
                                i, out_fmt_a, out_imm_a, out_target_a, fmt_t[i], imm_t[i], tgt_t[i]);
            end
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h123450B7, 64'h10, 1'b0, 1'b0);
        drive(1'b1, 32'hFFF00093, 64'h20, 1'b0, 1'b0);
        total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL bp_full_rdy got=%b want=0", in_ready_a); end
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        total++;
        if (out_valid_a !== 1'b1 || out_imm_a !== 32'h12345000 || out_pc_a !== 32'h10) begin
            bad++; $display("FAIL bp_hold got vld=%b imm=%h pc=%h want 1/12345000/10", out_valid_a, out_imm_a, out_pc_a);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        total++;
        if (out_valid_a !== 1'b1 || out_imm_a !== 32'hFFFFFFFF || out_pc_a !== 32'h20 || in_ready_a !== 1'b1) begin
            bad++; $display("FAIL bp_second got vld=%b imm=%h pc=%h rdy=%b want 1/ffffffff/20/1",
                            out_valid_a, out_imm_a, out_pc_a, in_ready_a);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid_a); end
    endtask

    task automatic test_shamt();
        drive(1'b1, 32'h4030D093, 64'h0, 1'b1, 1'b0);
        total++;
        if (out_fmt_a !== 3'd1 || out_imm_a !== 32'h3) begin
            bad++; $display("FAIL shamt_on got fmt=%0d imm=%h want 1/3", out_fmt_a, out_imm_a);
        end
        total++;
        if (out_fmt_n !== 3'd1 || out_imm_n !== 32'h403) begin
            bad++; $display("FAIL shamt_off got fmt=%0d imm=%h want 1/403", out_fmt_n, out_imm_n);
        end
        total++; if (out_imm_w !== 64'h3) begin bad++; $display("FAIL shamt_64 got=%h want=3", out_imm_w); end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal_rtype();
        drive(1'b1, 32'h0000007F, 64'h40, 1'b1, 1'b0);
        total++;
        if (out_fmt_a !== 3'd7 || out_imm_a !== 32'h0 || out_target_a !== 32'h40) begin
            bad++; $display("FAIL illegal got fmt=%0d imm=%h tgt=%h want 7/0/40", out_fmt_a, out_imm_a, out_target_a);
        end
        drive(1'b1, 32'h002081B3, 64'h44, 1'b1, 1'b0);
        total++;
        if (out_fmt_a !== 3'd0 || out_imm_a !== 32'h0 || out_target_a !== 32'h44) begin
            bad++; $display("FAIL rtype got fmt=%0d imm=%h tgt=%h want 0/0/44", out_fmt_a, out_imm_a, out_target_a);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h123450B7, 64'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h00112223, 64'h0, 1'b0, 1'b0);
        drive(1'b1, 32'hFFF00093, 64'h0, 1'b1, 1'b1);
        total++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            bad++; $display("FAIL flush got vld=%b rdy=%b want 0/1", out_valid_a, in_ready_a);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL flush_discard got=%b want=0", out_valid_a); end
    endtask

    task automatic test_xlen64();
        drive(1'b1, 32'h123450B7, 64'h0, 1'b1, 1'b0);
        total++; if (out_imm_w !== 64'h0000000012345000) begin bad++; $display("FAIL lui64 got=%h want=0000000012345000", out_imm_w); end
        drive(1'b1, 32'h02000093, 64'hFFFFFFFFFFFFFFF0, 1'b1, 1'b0);
        total++; if (out_target_w !== 64'h10) begin bad++; $display("FAIL wrap64 got=%h want=10", out_target_w); end
        total++; if (out_target_a !== 32'h10) begin bad++; $display("FAIL wrap32 got=%h want=10", out_target_a); end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 32'h123450B7, 64'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h00112223, 64'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_imm_a !== 32'h0) begin
            bad++; $display("FAIL mid_reset got vld=%b rdy=%b imm=%h want 0/1/0", out_valid_a, in_ready_a, out_imm_a);
        end
        do_reset();
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic [6:0]  ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h13};
        logic [63:0] ei;
        logic [2:0]  ef;
        logic [31:0] ins;
        logic [63:0] pc;
        logic        v, ordy, fl, acc;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            total++;
            if (out_valid_a !== (q.size() > 0) || in_ready_a !== (q.size() < 2)) begin
                bad++; $display("FAIL rnd_hs cyc=%0d got vld=%b rdy=%b want occupancy=%0d", cyc, out_valid_a, in_ready_a, q.size());
            end
            total++;
            if (out_valid_n !== out_valid_a || out_valid_w !== out_valid_a || in_ready_w !== in_ready_a || in_ready_n !== in_ready_a) begin
                bad++; $display("FAIL rnd_hs_var cyc=%0d got n=%b%b w=%b%b want occupancy=%0d",
                                cyc, out_valid_n, in_ready_n, out_valid_w, in_ready_w, q.size());
            end
            if (q.size() > 0) begin
                ref_dec(q[0].ins, 32, 1'b1, ei, ef);
                total++;
                if (out_fmt_a !== ef || out_imm_a !== ei[31:0] || out_target_a !== q[0].pc[31:0] + ei[31:0] || out_pc_a !== q[0].pc[31:0]) begin
                    bad++; $display("FAIL rnd_a cyc=%0d ins=%h got fmt=%0d imm=%h tgt=%h want fmt=%0d imm=%h",
                                    cyc, q[0].ins, out_fmt_a, out_imm_a, out_target_a, ef, ei[31:0]);
                end
                ref_dec(q[0].ins, 32, 1'b0, ei, ef);
                total++;
                if (out_fmt_n !== ef || out_imm_n !== ei[31:0] || out_target_n !== q[0].pc[31:0] + ei[31:0]) begin
                    bad++; $display("FAIL rnd_n cyc=%0d ins=%h got fmt=%0d imm=%h want fmt=%0d imm=%h",
                                    cyc, q[0].ins, out_fmt_n, out_imm_n, ef, ei[31:0]);
                end
                ref_dec(q[0].ins, 64, 1'b1, ei, ef);
                total++;
                if (out_fmt_w !== ef || out_imm_w !== ei || out_target_w !== q[0].pc + ei || out_pc_w !== q[0].pc) begin
                    bad++; $display("FAIL rnd_w cyc=%0d ins=%h got fmt=%0d imm=%h tgt=%h want fmt=%0d imm=%h",
                                    cyc, q[0].ins, out_fmt_w, out_imm_w, out_target_w, ef, ei);
                end
            end
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            ins  = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
            pc   = {$urandom, $urandom};
            if (fl) begin
                q.delete();
            end else begin
                acc = v && (q.size() < 2);
                if (q.size() > 0 && ordy) void'(q.pop_front());
                if (acc) q.push_back('{ins: ins, pc: pc});
            end
            drive(v, ins, pc, ordy, fl);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_shamt();
        test_illegal_rtype();
        test_flush();
        test_xlen64();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
